// File: rtl/bv_ic_pkg.sv
// Shared types and bit-vector helpers for the bvshl/bvsge witness sequencer.
// Helpers work on a wide container; the live width is passed as an argument.
package bv_ic_pkg;

    localparam int MAXW = 32;

    typedef logic [MAXW-1:0] bv_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        RESP
    } state_t;

    function automatic bv_t mask_w(input int unsigned w);
        if (w >= MAXW) return '1;
        return (bv_t'(1) << w) - bv_t'(1);
    endfunction

    // Left shift truncated to w bits; shifting by w or more yields 0.
    function automatic bv_t shl_w(input bv_t x, input bv_t s,
                                  input int unsigned w);
        if (s >= bv_t'(w)) return '0;
        return (x << s) & mask_w(w);
    endfunction

    // Signed a >= b on the low w bits: move the w-bit sign to the top.
    function automatic logic sge_w(input bv_t a, input bv_t b,
                                   input int unsigned w);
        int unsigned sh;
        sh = MAXW - w;
        return $signed(a << sh) >= $signed(b << sh);
    endfunction

endpackage

// File: rtl/bvshl_sge_ic.sv
// Invertibility condition for (x << s) >=s t: true when some x exists.
// Ports: s (shift), t (target) in; ic out. Purely combinational.
module bvshl_sge_ic
    import bv_ic_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    output logic         ic
);

    // Largest positive w-bit value.
    localparam bv_t SMAX = (bv_t'(1) << (W - 1)) - bv_t'(1);

    // x << s covers every value whose low s bits are zero, so the best
    // reachable signed value is SMAX with its low s bits cleared
    // (0 once s >= W-1).
    bv_t best;

    always_comb begin
        best = SMAX & shl_w('1, bv_t'(s), W);
        ic   = sge_w(best, bv_t'(t), W);
    end

endmodule

// File: rtl/bvshl_sge_witness_seq.sv
// Scans x = 0..2^W-1 for (x << s) >=s t, one candidate per cycle.
// Ports: req_* query handshake, rsp_* result handshake, cnt_* statistics.
module bvshl_sge_witness_seq
    import bv_ic_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_s,
    input  logic [W-1:0]  req_t,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_sat,
    output logic [W-1:0]  rsp_x,
    output logic          rsp_ic,
    output logic          rsp_mismatch,
    output logic [CW-1:0] cnt_sat,
    output logic [CW-1:0] cnt_unsat,
    output logic [CW-1:0] cnt_mismatch
);

    state_t       state;
    logic [W-1:0] s_q;
    logic [W-1:0] t_q;
    logic [W-1:0] x;
    bv_t          p;
    logic         hit;
    logic         last;
    logic         ic;

    bvshl_sge_ic #(.W(W)) u_ic (
        .s  (s_q),
        .t  (t_q),
        .ic (ic)
    );

    always_comb begin
        p    = shl_w(bv_t'(x), bv_t'(s_q), W);
        hit  = sge_w(p, bv_t'(t_q), W);
        last = &x;
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_sat      <= 1'b0;
            rsp_x        <= '0;
            rsp_ic       <= 1'b0;
            rsp_mismatch <= 1'b0;
            s_q          <= '0;
            t_q          <= '0;
            x            <= '0;
            cnt_sat      <= '0;
            cnt_unsat    <= '0;
            cnt_mismatch <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        s_q       <= req_s;
                        t_q       <= req_t;
                        x         <= '0;
                        req_ready <= 1'b0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit || last) begin
                        rsp_valid    <= 1'b1;
                        rsp_sat      <= hit;
                        rsp_x        <= hit ? x : '0;
                        rsp_ic       <= ic;
                        rsp_mismatch <= ic != hit;
                        if (hit) cnt_sat <= sat_inc(cnt_sat);
                        else cnt_unsat <= sat_inc(cnt_unsat);
                        if (ic != hit)
                            cnt_mismatch <= sat_inc(cnt_mismatch);
                        state <= RESP;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
